led_scan_ctrl: RTL

//  Sequencer that drives the 3-bit LED select of the 8-LED active-low one-hot decoder.

---
 rtl/led_scan_ctrl.sv | 112 +++++++++++
 1 files changed

// File: rtl/led_scan_ctrl.sv
// led_scan_ctrl: 3-bit LED index sequencer with manual pass-through and
// automatic up / down / ping-pong stepping, plus active-low one-hot decode.
module led_scan_ctrl #(
  parameter int DIV = 4,   // enabled cycles per automatic step (1..255)
  parameter int CW  = 8    // prescaler width, 2**CW > DIV-1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [2:0] switch,
  input  logic [1:0] mode,
  output logic [2:0] sel,
  output logic [7:0] led,
  output logic       tick,
  output logic       wrap
);

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_t;

  localparam logic [1:0]    MODE_MAN = 2'b00;
  localparam logic [1:0]    MODE_UP  = 2'b01;
  localparam logic [1:0]    MODE_DN  = 2'b10;
  localparam logic [1:0]    MODE_PP  = 2'b11;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    sel_q, sel_d;
  dir_t          dir_q, dir_d;
  logic          wrap_q, wrap_d;
  logic          tick_w;

  // Terminal count only exists in the automatic modes and while running.
  assign tick_w = enable && (mode != MODE_MAN) && (cnt_q == CNT_LAST);

  // State register; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      sel_q  <= 3'd0;
      dir_q  <= DIR_UP;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sel_q  <= sel_d;
      dir_q  <= dir_d;
      wrap_q <= wrap_d;
    end
  end

  // Next-state: prescaler, index stepping and end-of-sweep pulse.
  always_comb begin
    cnt_d  = cnt_q;
    sel_d  = sel_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    if (enable) begin
      if (mode == MODE_MAN) begin
        // Holding cnt at 0 here makes leaving manual mode restart the prescaler.
        cnt_d = '0;
        sel_d = switch;
      end else begin
        cnt_d = tick_w ? '0 : cnt_q + CW'(1);
        if (tick_w) begin
          case (mode)
            MODE_UP: begin
              sel_d  = sel_q + 3'd1;
              wrap_d = (sel_q == 3'd7);
            end
            MODE_DN: begin
              sel_d  = sel_q - 3'd1;
              wrap_d = (sel_q == 3'd0);
            end
            MODE_PP: begin
              // End points turn around without being repeated.
              if (sel_q == 3'd7) begin
                dir_d  = DIR_DN;
                sel_d  = 3'd6;
                wrap_d = 1'b1;
              end else if (sel_q == 3'd0) begin
                dir_d  = DIR_UP;
                sel_d  = 3'd1;
                wrap_d = 1'b1;
              end else if (dir_q == DIR_UP) begin
                sel_d = sel_q + 3'd1;
              end else begin
                sel_d = sel_q - 3'd1;
              end
            end
            default: begin
              sel_d = sel_q;
            end
          endcase
        end
      end
    end
  end

  // Active-low one-hot decode of the registered index.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_led
      assign led[gi] = (sel_q != 3'(gi));
    end
  endgenerate

  assign sel  = sel_q;
  assign tick = tick_w;
  assign wrap = wrap_q;

endmodule
